quad_enc_array: RTL and testbench
=================================

QUAD_ENC_ARRAY -- requirements
Module: quad_enc_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 3; number of encoder channels, legal 1-8.
REQ-002 SHALL have parameter CNT_W, default 8; position counter width, legal 4-16.
REQ-003 SHALL have parameter MAX_VAL, default 159; common upper count limit, must be < 2^CNT_W.
REQ-004 SHALL have parameter WRAP, default 1; 1 = wrap at limits, 0 = saturate.
REQ-005 SHALL have parameter FILT_LEN, default 16; input debounce stable-cycle count, legal 1-255.
REQ-006 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port enc_a  input  NUM_CH  quadrature A per channel, asynchronous.
REQ-009 SHALL have port enc_b  input  NUM_CH  quadrature B per channel, asynchronous.
REQ-010 SHALL have port enc_sw  input  NUM_CH  push-switch per channel, asynchronous, high = pressed.
REQ-011 SHALL have port clr  input  NUM_CH  synchronous per-channel position clear.
REQ-012 SHALL have port pos  output  NUM_CH*CNT_W  packed positions; channel i at bits [i*CNT_W +: CNT_W].
REQ-013 SHALL have port step  output  NUM_CH  one-cycle pulse per position update.
REQ-014 SHALL have port dir  output  NUM_CH  direction of last step; 1 = up.
REQ-015 SHALL have port sw_press  output  NUM_CH  one-cycle pulse on filtered switch rising edge.
REQ-016 SHALL have port rd_en  input  1  read strobe.
REQ-017 SHALL have port rd_sel  input  max(1,clog2(NUM_CH))  channel to read.
REQ-018 SHALL have port rd_data  output  CNT_W  registered position of selected channel.
REQ-019 SHALL have port rd_valid  output  1  high one cycle after a rd_en.
REQ-020 SHALL have port rd_changed  output  1  changed flag of selected channel, captured before clear.

Function
REQ-021 SHALL pass each of enc_a, enc_b, enc_sw through a 2-flop synchroniser.
REQ-022 SHALL filter each synchronised input with a counter: filtered value takes the synchronised value after FILT_LEN consecutive differing cycles; counter resets to 0 whenever they match.
REQ-023 SHALL register the filtered A value and detect a rising edge of filtered A per channel.
REQ-024 SHALL on a filtered A rising edge, increment position if filtered B = 0, decrement if filtered B = 1, updating pos on the next clock edge (pin-to-pos latency FILT_LEN+3 cycles).
REQ-025 SHALL, on increment at MAX_VAL, go to 0 when WRAP=1, hold MAX_VAL when WRAP=0.
REQ-026 SHALL, on decrement at 0, go to MAX_VAL when WRAP=1, hold 0 when WRAP=0.
REQ-027 SHALL assert step and update dir in the same cycle pos changes; saturated holds produce no step and keep dir unchanged.
REQ-028 SHALL give clr priority over a simultaneous step: pos = 0, no step pulse, changed flag set.
REQ-029 SHALL keep a per-channel changed flag, set on every pos change or clr.
REQ-030 SHALL on rd_en, register pos and changed flag of rd_sel into rd_data/rd_changed, pulse rd_valid next cycle, and clear that flag.
REQ-031 SHALL leave the flag set if a pos change on the read channel coincides with its rd_en (set wins).
REQ-032 SHALL ignore rd_en with rd_sel >= NUM_CH: rd_data = 0, rd_changed = 0, rd_valid still pulses.
REQ-033 SHALL keep channels fully independent; simultaneous steps on all channels all take effect.

Reset
REQ-034 SHALL on rst clear pos, dir, step, sw_press, changed flags, rd_data, rd_valid, rd_changed, all synchroniser, filter and edge registers to 0, immediately and regardless of clk.
REQ-035 SHALL, when rst is released while an input is high, not generate a step or sw_press until that input is filtered through REQ-022 (rising edge relative to reset value 0 counts as a real edge).
REQ-036 SHALL abort a partially filtered transition on rst; filter restarts from 0.

Verification
REQ-037 Defaults, ch0 B=0, 5 A pulses each held 20 cycles -> pos[7:0] = 5, 5 step pulses, dir[0] = 1, each step FILT_LEN+3 cycles after A rise.
REQ-038 WRAP=1, ch1 at 0, one A pulse with B=1 -> pos ch1 = 159; WRAP=0 same stimulus -> stays 0, no step.
REQ-039 A glitch high for FILT_LEN-1 cycles -> no step, pos unchanged.
REQ-040 clr[2] and a step on ch2 in the same cycle -> pos ch2 = 0, step[2] = 0; then rd_en, rd_sel=2 -> rd_valid next cycle, rd_data = 0, rd_changed = 1; second read -> rd_changed = 0.
REQ-041 ch0 step landing in the same cycle as rd_en, rd_sel=0 -> rd_changed reflects prior flag, flag remains set for following read.
REQ-042 rst asserted mid-filter with A held high after release -> pos = 0 during reset, exactly one step FILT_LEN+3 cycles after release.

Source files
------------

// File: rtl/quad_enc_array.sv
// Multi-channel quadrature encoder front end: synchronise and debounce A/B/switch pins,
// track a bounded position per channel and expose a strobed read port with change flags.
module quad_enc_array #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_VAL  = 159,
    parameter int unsigned WRAP     = 1,
    parameter int unsigned FILT_LEN = 16,
    localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         enc_a,
    input  logic [NUM_CH-1:0]         enc_b,
    input  logic [NUM_CH-1:0]         enc_sw,
    input  logic [NUM_CH-1:0]         clr,
    output logic [NUM_CH*CNT_W-1:0]   pos,
    output logic [NUM_CH-1:0]         step,
    output logic [NUM_CH-1:0]         dir,
    output logic [NUM_CH-1:0]         sw_press,
    input  logic                      rd_en,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic [CNT_W-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      rd_changed
);

    localparam int NIN = 3 * NUM_CH;
    localparam logic [7:0] FILT_LAST = 8'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] MAX_POS = CNT_W'(MAX_VAL);

    // All pins share one synchroniser/filter bank: A in the low third, then B, then switch.
    logic [NIN-1:0] rawIn, syncQ1, syncQ2, filtQ, filtD;
    logic [7:0]     cntQ [NIN];
    logic [7:0]     cntD [NIN];

    assign rawIn = {enc_sw, enc_b, enc_a};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ1 <= '0;
            syncQ2 <= '0;
            filtQ  <= '0;
            for (int i = 0; i < NIN; i++) cntQ[i] <= '0;
        end else begin
            syncQ1 <= rawIn;
            syncQ2 <= syncQ1;
            filtQ  <= filtD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        filtD = filtQ;
        for (int i = 0; i < NIN; i++) begin
            cntD[i] = '0;
            if (syncQ2[i] != filtQ[i]) begin
                if (cntQ[i] == FILT_LAST) filtD[i] = syncQ2[i];
                else                      cntD[i] = cntQ[i] + 8'd1;
            end
        end
    end

    logic [NUM_CH-1:0] filtA, filtB, filtSw, aPrevQ, swPrevQ, aRise;

    assign filtA  = filtQ[NUM_CH-1:0];
    assign filtB  = filtQ[2*NUM_CH-1:NUM_CH];
    assign filtSw = filtQ[NIN-1:2*NUM_CH];
    assign aRise  = filtA & ~aPrevQ;

    logic [CNT_W-1:0]  posQ [NUM_CH];
    logic [CNT_W-1:0]  posD [NUM_CH];
    logic [NUM_CH-1:0] stepQ, stepD, dirQ, dirD, chgQ, chgD, swPressQ;
    logic [CNT_W-1:0]  rdDataQ, rdPos;
    logic              rdValidQ, rdChgQ, rdChg;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            posD[i]  = posQ[i];
            stepD[i] = 1'b0;
            dirD[i]  = dirQ[i];
            chgD[i]  = chgQ[i];
            if (rd_en && rd_sel == SEL_W'(i)) chgD[i] = 1'b0;
            // Clear beats a coincident step; a pos change beats a coincident read-clear.
            if (clr[i]) begin
                posD[i] = '0;
                chgD[i] = 1'b1;
            end else if (aRise[i]) begin
                if (!filtB[i]) begin
                    if (posQ[i] != MAX_POS) posD[i] = posQ[i] + CNT_W'(1);
                    else if (WRAP != 0)     posD[i] = '0;
                    stepD[i] = (posQ[i] != MAX_POS) || (WRAP != 0);
                    if (stepD[i]) dirD[i] = 1'b1;
                end else begin
                    if (posQ[i] != '0)  posD[i] = posQ[i] - CNT_W'(1);
                    else if (WRAP != 0) posD[i] = MAX_POS;
                    stepD[i] = (posQ[i] != '0) || (WRAP != 0);
                    if (stepD[i]) dirD[i] = 1'b0;
                end
                if (stepD[i]) chgD[i] = 1'b1;
            end
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        rdPos = '0;
        rdChg = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rdPos = posQ[i];
                rdChg = chgQ[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) posQ[i] <= '0;
            stepQ    <= '0;
            dirQ     <= '0;
            chgQ     <= '0;
            aPrevQ   <= '0;
            swPrevQ  <= '0;
            swPressQ <= '0;
            rdDataQ  <= '0;
            rdValidQ <= 1'b0;
            rdChgQ   <= 1'b0;
        end else begin
            posQ     <= posD;
            stepQ    <= stepD;
            dirQ     <= dirD;
            chgQ     <= chgD;
            aPrevQ   <= filtA;
            swPrevQ  <= filtSw;
            swPressQ <= filtSw & ~swPrevQ;
            rdValidQ <= rd_en;
            if (rd_en) begin
                rdDataQ <= rdPos;
                rdChgQ  <= rdChg;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gPos
        assign pos[g*CNT_W +: CNT_W] = posQ[g];
    end

    assign step       = stepQ;
    assign dir        = dirQ;
    assign sw_press   = swPressQ;
    assign rd_data    = rdDataQ;
    assign rd_valid   = rdValidQ;
    assign rd_changed = rdChgQ;

endmodule

// File: tb/tb_quad_enc_array.sv
// Randomised scoreboard bench for quad_enc_array: a cycle-level event model predicts every
// step/pos/dir/sw_press/read response; a separate monitor compares on each falling edge.
module tb_quad_enc_array;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int MAXV   = 159;
    localparam int F      = 16;
    localparam int SEL_W  = 2;
    localparam int S_MAX  = 3;
    localparam int S_F    = 4;

    localparam int EV_STEP = 0;
    localparam int EV_CLR  = 1;
    localparam int EV_SW   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]       enc_a, enc_b, enc_sw, clr, step, dir, sw_press;
    logic [NUM_CH*CNT_W-1:0] pos;
    logic                    rd_en, rd_valid, rd_changed;
    logic [SEL_W-1:0]        rd_sel;
    logic [CNT_W-1:0]        rd_data;

    logic [NUM_CH-1:0]       sA, sB, sClr, sStep, sDir, sSwPress;
    logic [NUM_CH*CNT_W-1:0] sPos;
    logic                    sRdValid, sRdChanged;
    logic [CNT_W-1:0]        sRdData;

    quad_enc_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAX_VAL(MAXV), .WRAP(1), .FILT_LEN(F)) dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw), .clr(clr),
        .pos(pos), .step(step), .dir(dir), .sw_press(sw_press), .rd_en(rd_en),
        .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid), .rd_changed(rd_changed)
    );

    quad_enc_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAX_VAL(S_MAX), .WRAP(0), .FILT_LEN(S_F)) dutS (
        .clk(clk), .rst(rst), .enc_a(sA), .enc_b(sB), .enc_sw('0), .clr(sClr),
        .pos(sPos), .step(sStep), .dir(sDir), .sw_press(sSwPress), .rd_en(1'b0),
        .rd_sel('0), .rd_data(sRdData), .rd_valid(sRdValid), .rd_changed(sRdChanged)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int sStepCnt = 0;

    typedef struct { int cyc; int kind; int ch; int pos; bit dir; } ev_t;
    typedef struct { int cyc; int data; bit chg; } rd_t;
    ev_t evQ[$];
    rd_t rdQ[$];

    // Model state as it will stand once every issued event has landed.
    int modelPos [NUM_CH];
    bit modelChg [NUM_CH];

    int                      expPos [NUM_CH];
    logic [NUM_CH-1:0]       expStep, expDir, expSw;
    logic [NUM_CH*CNT_W-1:0] expPacked;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: applies due events to the expected view and compares every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < NUM_CH; i++) expPos[i] = 0;
                expStep = '0; expDir = '0; expSw = '0;
            end else begin
                sStepCnt += $countones(sStep);
                expStep = '0; expSw = '0;
                for (int k = evQ.size() - 1; k >= 0; k--) begin
                    if (evQ[k].cyc < cyc) begin
                        tests++; fails++;
                        $display("FAIL event_missed: cycle %0d ch %0d not applied (now %0d)",
                                 evQ[k].cyc, evQ[k].ch, cyc);
                        evQ.delete(k);
                    end else if (evQ[k].cyc == cyc) begin
                        if (evQ[k].kind == EV_STEP) begin
                            expStep[evQ[k].ch] = 1'b1;
                            expPos[evQ[k].ch]  = evQ[k].pos;
                            expDir[evQ[k].ch]  = evQ[k].dir;
                        end else if (evQ[k].kind == EV_CLR) begin
                            expPos[evQ[k].ch] = 0;
                        end else begin
                            expSw[evQ[k].ch] = 1'b1;
                        end
                        evQ.delete(k);
                    end
                end
                for (int i = 0; i < NUM_CH; i++) expPacked[i*CNT_W +: CNT_W] = CNT_W'(expPos[i]);
                tests++;
                if (step !== expStep || pos !== expPacked || dir !== expDir || sw_press !== expSw) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d step=%b want %b pos=%h want %h dir=%b want %b sw_press=%b want %b",
                             cyc, step, expStep, pos, expPacked, dir, expDir, sw_press, expSw);
                end
                if (rdQ.size() > 0 && rdQ[0].cyc == cyc) begin
                    rd_t r;
                    r = rdQ.pop_front();
                    tests++;
                    if (rd_valid !== 1'b1 || rd_data !== CNT_W'(r.data) || rd_changed !== r.chg) begin
                        fails++;
                        $display("FAIL read cyc=%0d valid=%b data=%0d chg=%b, expected valid=1 data=%0d chg=%b",
                                 cyc, rd_valid, rd_data, rd_changed, r.data, r.chg);
                    end
                end else if (rd_valid !== 1'b0) begin
                    tests++; fails++;
                    $display("FAIL read_unexpected cyc=%0d rd_valid=%b, expected 0", cyc, rd_valid);
                end
            end
        end
    end

    task automatic waitCyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stepModel(input int ch, input bit down, input int t);
        int np;
        np = down ? (modelPos[ch] + MAXV) % (MAXV + 1) : (modelPos[ch] + 1) % (MAXV + 1);
        modelPos[ch] = np;
        modelChg[ch] = 1'b1;
        evQ.push_back('{t, EV_STEP, ch, np, !down});
    endtask

    task automatic raiseA(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] bv,
                          input logic [NUM_CH-1:0] supp, output int c);
        logic [NUM_CH-1:0] nb;
        nb = (enc_b & ~mask) | (bv & mask);
        if (nb != enc_b) begin
            enc_b = nb;
            waitCyc(cyc + F + 4);
        end
        enc_a = enc_a | mask;
        c = cyc;
        for (int i = 0; i < NUM_CH; i++)
            if (mask[i] && !supp[i]) stepModel(i, bv[i], c + F + 3);
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] bv,
                         input int hi, input int lo);
        int c;
        raiseA(mask, bv, '0, c);
        waitCyc(c + hi);
        enc_a = enc_a & ~mask;
        waitCyc(c + hi + lo);
    endtask

    task automatic glitch(input int ch, input int hi);
        int c;
        enc_a[ch] = 1'b1;
        c = cyc;
        waitCyc(c + hi);
        enc_a[ch] = 1'b0;
        waitCyc(c + hi + F + 4);
    endtask

    task automatic press(input int ch, input int hi, input int lo);
        int c;
        enc_sw[ch] = 1'b1;
        c = cyc;
        if (hi >= F) evQ.push_back('{c + F + 3, EV_SW, ch, 0, 1'b0});
        waitCyc(c + hi);
        enc_sw[ch] = 1'b0;
        waitCyc(c + hi + lo);
    endtask

    task automatic clrOp(input int ch);
        int c;
        clr[ch] = 1'b1;
        c = cyc;
        evQ.push_back('{c + 1, EV_CLR, ch, 0, 1'b0});
        modelPos[ch] = 0;
        modelChg[ch] = 1'b1;
        waitCyc(c + 1);
        clr[ch] = 1'b0;
        waitCyc(c + 2);
    endtask

    task automatic doReadExp(input int sel, input int data, input bit chg);
        int c;
        c = cyc;
        rd_en  = 1'b1;
        rd_sel = SEL_W'(sel);
        rdQ.push_back('{c + 1, data, chg});
        waitCyc(c + 1);
        rd_en = 1'b0;
    endtask

    task automatic doRead(input int sel);
        int d;
        bit ch;
        d = 0; ch = 1'b0;
        if (sel < NUM_CH) begin
            d = modelPos[sel];
            ch = modelChg[sel];
            modelChg[sel] = 1'b0;
        end
        doReadExp(sel, d, ch);
    endtask

    task automatic sPulse(input bit down);
        int c;
        sB[1] = down;
        waitCyc(cyc + S_F + 4);
        sA[1] = 1'b1;
        c = cyc;
        waitCyc(c + 8);
        sA[1] = 1'b0;
        waitCyc(c + 16);
    endtask

    initial begin
        int c, prior;
        rst = 1'b1;
        enc_a = '0; enc_b = '0; enc_sw = '0; clr = '0; rd_en = 1'b0; rd_sel = '0;
        sA = '0; sB = '0; sClr = '0;
        for (int i = 0; i < NUM_CH; i++) begin modelPos[i] = 0; modelChg[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        check("reset_pos", 32'(pos), 0);
        check("reset_step", 32'(step), 0);
        check("reset_dir", 32'(dir), 0);
        check("reset_sw_press", 32'(sw_press), 0);
        check("reset_rd", 32'({rd_valid, rd_changed, rd_data}), 0);
        rst = 1'b0;
        waitCyc(cyc + 2);

        // Five up-counts on channel 0.
        repeat (5) pulse(3'b001, 3'b000, 20, 20);
        check("five_pulses_pos0", 32'(pos[7:0]), 5);
        check("five_pulses_dir0", 32'(dir[0]), 1);

        // Down-count from 0 wraps to the limit.
        pulse(3'b010, 3'b010, 20, 20);
        check("wrap_down_pos1", 32'(pos[15:8]), MAXV);

        // A glitch one cycle short of the filter length is rejected.
        glitch(0, F - 1);
        check("glitch_pos0", 32'(pos[7:0]), 5);

        // Clear coinciding with a step on channel 2.
        pulse(3'b100, 3'b000, 20, 20);
        raiseA(3'b100, 3'b000, 3'b100, c);
        waitCyc(c + F + 2);
        clr[2] = 1'b1;
        evQ.push_back('{c + F + 3, EV_CLR, 2, 0, 1'b0});
        modelPos[2] = 0;
        modelChg[2] = 1'b1;
        waitCyc(c + F + 3);
        clr[2] = 1'b0;
        waitCyc(c + 20);
        enc_a[2] = 1'b0;
        waitCyc(c + 40);
        doRead(2);
        doRead(2);

        // Step landing on the same edge as a read of that channel.
        doRead(0);
        prior = modelPos[0];
        raiseA(3'b001, 3'b000, '0, c);
        waitCyc(c + F + 2);
        doReadExp(0, prior, 1'b0);
        waitCyc(c + 20);
        enc_a[0] = 1'b0;
        waitCyc(c + 40);
        doRead(0);
        doRead(3);

        // Simultaneous steps on all channels, mixed directions.
        pulse(3'b111, 3'b101, 20, 20);

        for (int n = 0; n < 60; n++) begin
            int ch;
            ch = int'($urandom_range(NUM_CH - 1, 0));
            case ($urandom_range(7, 0))
                0, 1, 2, 3: pulse(3'($urandom_range(7, 1)), 3'($urandom_range(7, 0)),
                                  int'($urandom_range(F + 6, F)), int'($urandom_range(F + 8, F + 3)));
                4:       glitch(ch, int'($urandom_range(F - 1, 1)));
                5:       clrOp(ch);
                6:       doRead(int'($urandom_range(3, 0)));
                default: press(ch, int'($urandom_range(F + 6, 1)), int'($urandom_range(F + 8, F + 3)));
            endcase
        end
        for (int i = 0; i < NUM_CH; i++) doRead(i);

        // Reset mid-filter with A held high across release.
        enc_b = '0;
        waitCyc(cyc + F + 4);
        enc_a[0] = 1'b1;
        c = cyc;
        waitCyc(c + F / 2);
        rst = 1'b1;
        #1;
        check("mid_reset_pos", 32'(pos), 0);
        check("mid_reset_step", 32'(step), 0);
        evQ.delete();
        rdQ.delete();
        for (int i = 0; i < NUM_CH; i++) begin modelPos[i] = 0; modelChg[i] = 1'b0; end
        waitCyc(cyc + 3);
        rst = 1'b0;
        c = cyc;
        stepModel(0, 1'b0, c + F + 3);
        waitCyc(c + F + 10);
        enc_a[0] = 1'b0;
        waitCyc(cyc + F + 4);
        check("post_reset_pos0", 32'(pos[7:0]), 1);
        doRead(0);

        // Saturating instance: limit 3, no wrap.
        sStepCnt = 0;
        sPulse(1'b1);
        check("sat_low_pos", 32'(sPos[15:8]), 0);
        check("sat_low_steps", 32'(sStepCnt), 0);
        repeat (4) sPulse(1'b0);
        check("sat_high_pos", 32'(sPos[15:8]), S_MAX);
        check("sat_high_steps", 32'(sStepCnt), 3);
        check("sat_high_dir", 32'(sDir[1]), 1);
        sClr[1] = 1'b1;
        waitCyc(cyc + 1);
        sClr[1] = 1'b0;
        waitCyc(cyc + 1);
        check("sat_clr_pos", 32'(sPos[15:8]), 0);
        sPulse(1'b1);
        check("sat_hold_dir", 32'(sDir[1]), 1);
        check("sat_hold_steps", 32'(sStepCnt), 3);
        check("sat_idle_outputs", 32'({sRdValid, sRdChanged, sRdData, sSwPress}), 0);

        waitCyc(cyc + 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
